// File: rtl/axi_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_boot_pkg
// Description : Shared AXI constants, preloader state encoding and the
//               buffered write-beat type used by the boot-time preloader.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_boot_pkg;

    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_FILL = 3'd1,
        ST_AW   = 3'd2,
        ST_W    = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/preload_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : preload_beat_fifo
// Description : Synchronous first-word-fall-through FIFO of write beats.
//               Ports: clk/rst (active-high sync), i_push/i_push_data,
//               i_pop, o_head (current head beat), o_count, o_full, o_empty.
//               Push and pop together while full are accepted; pop while
//               empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module preload_beat_fifo
    import axi_boot_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  beat_t            i_push_data,
    input  logic             i_pop,
    output beat_t            o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    beat_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot being written.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_mem_preloader.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_preloader
// Description : Boot-time loader owning the memory AXI write port while the
//               core is held in reset. Takes a byte stream (8-byte LE length
//               header + image), packs bytes into 64-bit beats, writes them
//               with INCR bursts starting at BASE_ADDR, then releases the core.
//               Ports: clock/reset_n (sync active-low); s_* host byte stream;
//               m_aw*/m_w*/m_b* AXI write master; mem_owner, core_reset_n,
//               done, error status.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_preloader
    import axi_boot_pkg::*;
#(
    parameter int          ADDR_W    = 64,
    parameter int          ID_W      = 5,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          MAX_BEATS = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic [ID_W-1:0]   m_awid,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [63:0]       m_wdata,
    output logic [7:0]        m_wstrb,
    output logic              m_wlast,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,
    output logic              mem_owner,
    output logic              core_reset_n,
    output logic              done,
    output logic              error
);

    localparam int c_CNT_W       = $clog2(MAX_BEATS + 1);
    localparam int c_BURST_SHIFT = $clog2(MAX_BEATS * 8);

    state_t              r_state;
    logic                r_armed;       // keeps s_ready low while reset is held
    logic [2:0]          r_hdr_cnt;
    logic [63:0]         r_len;
    logic [63:0]         r_accepted;
    logic [63:0]         r_pack_data;
    logic [2:0]          r_lane;
    logic [ADDR_W-1:0]   r_burst_idx;
    logic [7:0]          r_awlen;
    logic [7:0]          r_wbeat;
    logic                r_awvalid;
    logic                r_bready;
    logic                r_mem_owner;
    logic                r_core_reset_n;
    logic                r_done;
    logic                r_error;

    logic                w_fifo_rst;
    logic                w_fire;
    logic                w_hdr_fire;
    logic                w_pay_fire;
    logic                w_payload_state;
    logic                w_final;
    logic                w_beat_done;
    logic [63:0]         w_len_next;
    logic [63:0]         w_pack_next;
    logic                w_push;
    beat_t               w_push_beat;
    logic                w_pop;
    beat_t               w_head;
    logic [c_CNT_W-1:0]  w_count;
    logic                w_full;
    logic                w_empty;

    assign w_payload_state = (r_state == ST_FILL) || (r_state == ST_AW) ||
                             (r_state == ST_W)    || (r_state == ST_B);

    // Payload bytes are only taken while a FIFO slot is free and LEN is not
    // yet reached, so the accepted count can never pass LEN.
    assign s_ready = r_armed &&
                     ((r_state == ST_HDR) ||
                      (w_payload_state && !w_full && (r_accepted != r_len)));

    assign w_fire      = s_valid && s_ready;
    assign w_hdr_fire  = w_fire && (r_state == ST_HDR);
    assign w_pay_fire  = w_fire && (r_state != ST_HDR);
    assign w_len_next  = {s_data, r_len[63:8]};
    assign w_final     = ((r_accepted + 64'd1) == r_len);
    assign w_beat_done = (r_lane == 3'd7) || w_final;
    assign w_pack_next = r_pack_data | ({56'd0, s_data} << {r_lane, 3'b000});

    // Lanes above the final byte stay zero because the packer clears per beat.
    assign w_push           = w_pay_fire && w_beat_done;
    assign w_push_beat.data = w_pack_next;
    assign w_push_beat.strb = 8'hFF >> (3'd7 - r_lane);

    assign w_pop      = (r_state == ST_W) && m_wready && !w_empty;
    assign w_fifo_rst = !reset_n;

    preload_beat_fifo #(
        .DEPTH (MAX_BEATS)
    ) u_beat_fifo (
        .clk         (clock),
        .rst         (w_fifo_rst),
        .i_push      (w_push),
        .i_push_data (w_push_beat),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign m_awvalid    = r_awvalid;
    assign m_awaddr     = BASE_ADDR[ADDR_W-1:0] + (r_burst_idx << c_BURST_SHIFT);
    assign m_awlen      = r_awlen;
    assign m_awsize     = AXI_SIZE_8B;
    assign m_awburst    = AXI_BURST_INCR;
    assign m_awid       = '0;
    assign m_wvalid     = (r_state == ST_W) && !w_empty;
    assign m_wdata      = w_head.data;
    assign m_wstrb      = w_head.strb;
    assign m_wlast      = (r_state == ST_W) && (r_wbeat == r_awlen);
    assign m_bready     = r_bready;
    assign mem_owner    = r_mem_owner;
    assign core_reset_n = r_core_reset_n;
    assign done         = r_done;
    assign error        = r_error;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= ST_HDR;
            r_armed        <= 1'b0;
            r_hdr_cnt      <= '0;
            r_len          <= '0;
            r_accepted     <= '0;
            r_pack_data    <= '0;
            r_lane         <= '0;
            r_burst_idx    <= '0;
            r_awlen        <= '0;
            r_wbeat        <= '0;
            r_awvalid      <= 1'b0;
            r_bready       <= 1'b0;
            r_mem_owner    <= 1'b1;
            r_core_reset_n <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_armed <= 1'b1;

            if (w_hdr_fire) begin
                r_len     <= w_len_next;
                r_hdr_cnt <= r_hdr_cnt + 3'd1;
            end

            if (w_pay_fire) begin
                r_accepted <= r_accepted + 64'd1;
                if (w_beat_done) begin
                    r_pack_data <= '0;
                    r_lane      <= '0;
                end else begin
                    r_pack_data <= w_pack_next;
                    r_lane      <= r_lane + 3'd1;
                end
            end

            case (r_state)
                ST_HDR: begin
                    if (w_hdr_fire && (r_hdr_cnt == 3'd7)) begin
                        if (w_len_next == 64'd0) begin
                            r_state        <= ST_DONE;
                            r_done         <= 1'b1;
                            r_mem_owner    <= 1'b0;
                            r_core_reset_n <= 1'b1;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    // Burst when the buffer is full or the whole image is buffered.
                    if (w_full || ((r_accepted == r_len) && !w_empty)) begin
                        r_state   <= ST_AW;
                        r_awvalid <= 1'b1;
                        r_awlen   <= 8'(w_count) - 8'd1;
                    end
                end
                ST_AW: begin
                    if (m_awready) begin
                        r_awvalid <= 1'b0;
                        r_wbeat   <= '0;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_pop) begin
                        if (m_wlast) begin
                            r_state  <= ST_B;
                            r_bready <= 1'b1;
                        end else begin
                            r_wbeat <= r_wbeat + 8'd1;
                        end
                    end
                end
                ST_B: begin
                    if (m_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_bresp == AXI_RESP_OKAY) begin
                            r_burst_idx <= r_burst_idx + 1'b1;
                            if (!w_empty || (r_accepted != r_len)) begin
                                r_state <= ST_FILL;
                            end else begin
                                r_state        <= ST_DONE;
                                r_done         <= 1'b1;
                                r_mem_owner    <= 1'b0;
                                r_core_reset_n <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_DONE;
                ST_ERR:  r_state <= ST_ERR;
                default: r_state <= ST_HDR;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_preloader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_mem_preloader
// Description : Self-checking bench for axi_mem_preloader: host byte driver,
//               AXI write slave with memory model, expected AW/W queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_preloader;

    localparam logic [63:0] c_BASE = 64'h8000_0000;
    localparam int          c_MAXB = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic [4:0]  m_awid;
    logic        m_wvalid;
    logic        m_wready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast;
    logic        m_bvalid;
    logic        m_bready;
    logic [1:0]  m_bresp;
    logic        mem_owner;
    logic        core_reset_n;
    logic        done;
    logic        error;

    always #5 clock = ~clock;

    axi_mem_preloader #(
        .ADDR_W    (64),
        .ID_W      (5),
        .BASE_ADDR (c_BASE),
        .MAX_BEATS (c_MAXB)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_awvalid    (m_awvalid),
        .m_awready    (m_awready),
        .m_awaddr     (m_awaddr),
        .m_awlen      (m_awlen),
        .m_awsize     (m_awsize),
        .m_awburst    (m_awburst),
        .m_awid       (m_awid),
        .m_wvalid     (m_wvalid),
        .m_wready     (m_wready),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_wlast      (m_wlast),
        .m_bvalid     (m_bvalid),
        .m_bready     (m_bready),
        .m_bresp      (m_bresp),
        .mem_owner    (mem_owner),
        .core_reset_n (core_reset_n),
        .done         (done),
        .error        (error)
    );

    typedef struct packed { logic [63:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct packed { logic [63:0] data; logic [7:0] strb; logic last; } w_exp_t;

    aw_exp_t     exp_aw [$];
    w_exp_t      exp_w  [$];
    logic [7:0]  mem [logic [63:0]];
    logic [7:0]  img [$];

    int          vectors     = 0;
    int          miscompares = 0;
    bit          stall_en    = 1'b0;
    int          err_burst   = -1;
    int          aw_count    = 0;
    int          burst_no    = 0;

    // Slave / monitor state
    bit          aw_open, b_due, b_taken, prev_aw_stall, prev_w_stall;
    logic [63:0] cur_addr, prev_awaddr, prev_wdata;
    logic [7:0]  prev_awlen, prev_wstrb;
    logic        prev_wlast;
    int          beat_idx;
    aw_exp_t     ea;
    w_exp_t      ew;

    // AXI slave: readies and responses are driven on the falling edge; any
    // valid&&ready seen here completes at the following rising edge.
    initial begin
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
                aw_open = 0; b_due = 0; b_taken = 0; prev_aw_stall = 0; prev_w_stall = 0;
                aw_count = 0; burst_no = 0; beat_idx = 0;
            end else begin
                if (b_taken) begin m_bvalid = 1'b0; b_taken = 0; burst_no++; end
                if (b_due) begin
                    m_bvalid = 1'b1;
                    m_bresp  = (burst_no == err_burst) ? 2'b10 : 2'b00;
                    b_due    = 0;
                end
                if (m_bvalid && m_bready) b_taken = 1;

                if (prev_aw_stall) begin
                    vectors++;
                    if (!m_awvalid || m_awaddr !== prev_awaddr || m_awlen !== prev_awlen) begin
                        miscompares++;
                        $display("FAIL aw_stable: got valid=%0b addr=%h len=%0d, required valid=1 addr=%h len=%0d",
                                 m_awvalid, m_awaddr, m_awlen, prev_awaddr, prev_awlen);
                    end
                end
                if (prev_w_stall) begin
                    vectors++;
                    if (!m_wvalid || m_wdata !== prev_wdata || m_wstrb !== prev_wstrb || m_wlast !== prev_wlast) begin
                        miscompares++;
                        $display("FAIL w_stable: got valid=%0b data=%h strb=%h last=%0b, required valid=1 data=%h strb=%h last=%0b",
                                 m_wvalid, m_wdata, m_wstrb, m_wlast, prev_wdata, prev_wstrb, prev_wlast);
                    end
                end

                m_awready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
                m_wready  = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;

                if (m_wvalid) begin
                    vectors++;
                    if (!aw_open) begin
                        miscompares++;
                        $display("FAIL w_before_aw: got wvalid=1 with no accepted AW, required wvalid=0");
                    end
                end

                if (m_awvalid && m_awready) begin
                    aw_count++;
                    vectors++;
                    if (exp_aw.size() == 0) begin
                        miscompares++;
                        $display("FAIL aw_unexpected: got addr=%h len=%0d, required no AW", m_awaddr, m_awlen);
                    end else begin
                        ea = exp_aw.pop_front();
                        if (m_awaddr !== ea.addr || m_awlen !== ea.len) begin
                            miscompares++;
                            $display("FAIL aw_fields: got addr=%h len=%0d, required addr=%h len=%0d",
                                     m_awaddr, m_awlen, ea.addr, ea.len);
                        end
                    end
                    aw_open  = 1;
                    cur_addr = m_awaddr;
                    beat_idx = 0;
                end

                if (m_wvalid && m_wready) begin
                    vectors++;
                    if (exp_w.size() == 0) begin
                        miscompares++;
                        $display("FAIL w_unexpected: got data=%h strb=%h, required no beat", m_wdata, m_wstrb);
                    end else begin
                        ew = exp_w.pop_front();
                        if (m_wdata !== ew.data || m_wstrb !== ew.strb || m_wlast !== ew.last) begin
                            miscompares++;
                            $display("FAIL w_beat: got data=%h strb=%h last=%0b, required data=%h strb=%h last=%0b",
                                     m_wdata, m_wstrb, m_wlast, ew.data, ew.strb, ew.last);
                        end
                    end
                    for (int l = 0; l < 8; l++) begin
                        if (m_wstrb[l]) mem[cur_addr + 64'(beat_idx * 8 + l)] = m_wdata[8*l +: 8];
                    end
                    beat_idx++;
                    if (m_wlast) begin aw_open = 0; b_due = 1; end
                end

                prev_aw_stall = m_awvalid && !m_awready;
                prev_awaddr   = m_awaddr;
                prev_awlen    = m_awlen;
                prev_w_stall  = m_wvalid && !m_wready;
                prev_wdata    = m_wdata;
                prev_wstrb    = m_wstrb;
                prev_wlast    = m_wlast;
            end
        end
    end

    // Expected AW/W traffic derived from the image: MAX_BEATS-beat bursts,
    // little-endian lanes, partial final beat with low strobes only.
    task automatic push_expected(input int len);
        int nbeats;
        nbeats = (len + 7) / 8;
        for (int bi = 0; bi < nbeats; bi += c_MAXB) begin
            int      nb;
            aw_exp_t a;
            nb     = ((nbeats - bi) < c_MAXB) ? (nbeats - bi) : c_MAXB;
            a.addr = c_BASE + 64'(bi * 8);
            a.len  = 8'(nb - 1);
            exp_aw.push_back(a);
            for (int k = 0; k < nb; k++) begin
                w_exp_t w;
                w.data = '0;
                w.strb = '0;
                for (int l = 0; l < 8; l++) begin
                    if (((bi + k) * 8 + l) < len) begin
                        w.data[8*l +: 8] = img[(bi + k) * 8 + l];
                        w.strb[l]        = 1'b1;
                    end
                end
                w.last = (k == nb - 1);
                exp_w.push_back(w);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int guard;
        guard = 0;
        ok    = 1;
        if (stall_en && ($urandom_range(0, 3) == 0)) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready) begin
            if (error) begin ok = 0; s_valid = 1'b0; return; end
            @(negedge clock);
            guard++;
            if (guard > 4000) begin
                vectors++; miscompares++;
                $display("FAIL s_ready_timeout: got s_ready=0 for %0d cycles, required 1", guard);
                ok = 0; s_valid = 1'b0; return;
            end
        end
        @(negedge clock);
        s_valid = 1'b0;
    endtask

    task automatic send_image(input int len, input int nsend, output bit ok);
        logic [63:0] l64;
        l64 = 64'(len);
        for (int i = 0; i < 8; i++) begin
            send_byte(l64[8*i +: 8], ok);
            if (!ok) return;
        end
        for (int i = 0; i < nsend; i++) begin
            send_byte(img[i], ok);
            if (!ok) return;
        end
    endtask

    task automatic wait_end();
        int cyc;
        cyc = 0;
        while (!done && !error && cyc < 6000) begin @(negedge clock); cyc++; end
        if (!done && !error) begin
            vectors++; miscompares++;
            $display("FAIL end_timeout: got done=0 error=0 after %0d cycles, required done or error", cyc);
        end
    endtask

    task automatic check_image(input int len);
        for (int i = 0; i < len; i++) begin
            vectors++;
            if (!mem.exists(c_BASE + 64'(i)) || mem[c_BASE + 64'(i)] !== img[i]) begin
                miscompares++;
                $display("FAIL mem_byte[%0d]: got %h, required %h", i,
                         mem.exists(c_BASE + 64'(i)) ? mem[c_BASE + 64'(i)] : 8'hxx, img[i]);
            end
        end
        vectors++;
        if (exp_aw.size() != 0 || exp_w.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d AW and %0d W pending, required 0 and 0", exp_aw.size(), exp_w.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        s_valid = 1'b0;
        stall_en = 1'b0;
        err_burst = -1;
        repeat (3) @(negedge clock);
        exp_aw.delete(); exp_w.delete(); mem.delete(); img.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        obs = {s_ready, m_awvalid, m_wvalid, m_bready, mem_owner, core_reset_n, done, error,
               m_awsize, m_awburst, m_awid[2:0]};
        vectors++;
        if (obs !== {8'b0000_1000, 3'd3, 2'b01, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got %b, required %b", obs, {8'b0000_1000, 3'd3, 2'b01, 3'd0});
        end
        vectors++;
        if (m_awid !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_awid: got %h, required 00", m_awid);
        end
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if (s_ready !== 1'b1 || mem_owner !== 1'b1) begin
            miscompares++;
            $display("FAIL hdr_ready: got s_ready=%0b mem_owner=%0b, required 1 1", s_ready, mem_owner);
        end
    endtask

    task automatic test_len0();
        bit ok;
        do_reset();
        @(negedge clock);
        send_image(0, 0, ok);
        vectors++;
        if ({done, core_reset_n, mem_owner} !== 3'b110) begin
            miscompares++;
            $display("FAIL len0_done: got done=%0b core_reset_n=%0b mem_owner=%0b, required 1 1 0",
                     done, core_reset_n, mem_owner);
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (aw_count !== 0 || done !== 1'b1 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_idle: got aw_count=%0d done=%0b s_ready=%0b, required 0 1 0", aw_count, done, s_ready);
        end
    endtask

    task automatic run_load(input int len, input int exp_bursts, input bit stall, input bit rnd);
        bit ok;
        do_reset();
        stall_en = stall;
        for (int i = 0; i < len; i++) img.push_back(rnd ? 8'($urandom) : 8'(i));
        push_expected(len);
        @(negedge clock);
        send_image(len, len, ok);
        wait_end();
        check_image(len);
        vectors++;
        if (done !== 1'b1 || core_reset_n !== 1'b1 || mem_owner !== 1'b0 || error !== 1'b0 || aw_count !== exp_bursts) begin
            miscompares++;
            $display("FAIL load_%0d_status: got done=%0b core_reset_n=%0b mem_owner=%0b error=%0b bursts=%0d, required 1 1 0 0 %0d",
                     len, done, core_reset_n, mem_owner, error, aw_count, exp_bursts);
        end
    endtask

    task automatic test_bresp_error();
        bit ok;
        do_reset();
        err_burst = 1;
        for (int i = 0; i < 300; i++) img.push_back(8'(i * 7 + 3));
        push_expected(300);
        @(negedge clock);
        send_image(300, 300, ok);
        wait_end();
        repeat (20) @(negedge clock);
        vectors++;
        if ({error, done, core_reset_n, mem_owner, m_awvalid, m_wvalid, s_ready} !== 7'b1001000 || aw_count !== 2) begin
            miscompares++;
            $display("FAIL bresp_err: got error=%0b done=%0b core_reset_n=%0b mem_owner=%0b awvalid=%0b wvalid=%0b s_ready=%0b bursts=%0d, required 1 0 0 1 0 0 0 2",
                     error, done, core_reset_n, mem_owner, m_awvalid, m_wvalid, s_ready, aw_count);
        end
    endtask

    task automatic test_reset_mid_w();
        bit ok;
        int cyc;
        do_reset();
        for (int i = 0; i < 131; i++) img.push_back(8'(i));
        push_expected(131);
        @(negedge clock);
        send_image(131, 128, ok);
        cyc = 0;
        while (!m_wvalid && cyc < 100) begin @(negedge clock); cyc++; end
        vectors++;
        if (!m_wvalid) begin
            miscompares++;
            $display("FAIL midw_reach: got wvalid=0 after %0d cycles, required 1", cyc);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        vectors++;
        if ({m_awvalid, m_wvalid, m_bready, s_ready, core_reset_n, mem_owner, done} !== 7'b0000010) begin
            miscompares++;
            $display("FAIL midw_reset: got awv=%0b wv=%0b bready=%0b s_ready=%0b core_reset_n=%0b mem_owner=%0b done=%0b, required 0 0 0 0 0 1 0",
                     m_awvalid, m_wvalid, m_bready, s_ready, core_reset_n, mem_owner, done);
        end
        repeat (2) @(negedge clock);
        exp_aw.delete(); exp_w.delete(); mem.delete(); img.delete();
        reset_n = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 16; i++) img.push_back(8'(8'hA0 + i));
        push_expected(16);
        send_image(16, 16, ok);
        wait_end();
        check_image(16);
        vectors++;
        if (done !== 1'b1 || aw_count !== 1) begin
            miscompares++;
            $display("FAIL midw_reload: got done=%0b bursts=%0d, required 1 1", done, aw_count);
        end
    endtask

    initial begin
        test_reset();
        test_len0();
        run_load(24, 1, 1'b0, 1'b0);
        run_load(131, 2, 1'b0, 1'b0);
        run_load(300, 3, 1'b1, 1'b1);
        test_bresp_error();
        test_reset_mid_w();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
